// File: rtl/dmem_arbiter_pkg.sv
// Shared types and defaults for the data-memory arbiter: priority state encoding,
// default sizing, and the out-of-range address test used by the arbiter.
package dmem_arbiter_pkg;

  typedef enum logic {
    PriA = 1'b0,
    PriB = 1'b1
  } pri_e;

  localparam int unsigned MaxWaitDefault    = 3;
  localparam int unsigned DepthWordsDefault = 128;

  // Word index is addr[31:2]; byte offset bits never affect the range test.
  function automatic logic addr_oor(input logic [31:0] addr, input int unsigned depth_words);
    return {2'b00, addr[31:2]} >= depth_words;
  endfunction

endpackage

// File: rtl/dmem_port_resp.sv
// Per-port response registers: one-cycle rvalid/err pulses and read data that holds
// between reads.
module dmem_port_resp (
  input  logic        clk_i,
  input  logic        rst_ni,
  input  logic        gnt_i,
  input  logic        we_i,
  input  logic        oor_i,
  input  logic [31:0] mem_rd_i,
  output logic [31:0] rdata_o,
  output logic        rvalid_o,
  output logic        err_o
);

  logic [31:0] rdata_q, rdata_d;
  logic        rvalid_q, rvalid_d;
  logic        err_q, err_d;

  always_comb begin
    rvalid_d = gnt_i & ~we_i;
    err_d    = gnt_i & oor_i;
    rdata_d  = rdata_q;
    // Out-of-range reads still return a response, but with zero data.
    if (rvalid_d) begin
      rdata_d = oor_i ? 32'h0 : mem_rd_i;
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      rdata_q  <= 32'h0;
      rvalid_q <= 1'b0;
      err_q    <= 1'b0;
    end else begin
      rdata_q  <= rdata_d;
      rvalid_q <= rvalid_d;
      err_q    <= err_d;
    end
  end

  assign rdata_o  = rdata_q;
  assign rvalid_o = rvalid_q;
  assign err_o    = err_q;

endmodule

// File: rtl/dmem_arbiter.sv
// Two-port arbiter in front of a single-ported data memory: pipeline port A normally
// wins, debug/DMA port B gets priority after losing MAX_WAIT contested cycles.
module dmem_arbiter
  import dmem_arbiter_pkg::*;
#(
  parameter int unsigned MAX_WAIT    = MaxWaitDefault,
  parameter int unsigned DEPTH_WORDS = DepthWordsDefault
) (
  input  logic        clk,
  input  logic        rst_n,

  input  logic        a_req,
  input  logic        a_we,
  input  logic [31:0] a_addr,
  input  logic [31:0] a_wdata,
  output logic        a_gnt,
  output logic        a_rvalid,
  output logic        a_err,
  output logic [31:0] a_rdata,

  input  logic        b_req,
  input  logic        b_we,
  input  logic [31:0] b_addr,
  input  logic [31:0] b_wdata,
  output logic        b_gnt,
  output logic        b_rvalid,
  output logic        b_err,
  output logic [31:0] b_rdata,

  output logic [31:0] mem_add,
  output logic [31:0] mem_wd,
  output logic        mem_mw,
  output logic        mem_mre,
  input  logic [31:0] mem_rd
);

  localparam int unsigned CntW = (MAX_WAIT < 4) ? 2 : $clog2(MAX_WAIT + 1);
  localparam logic [CntW-1:0] CntMax = CntW'(MAX_WAIT);

  pri_e            pri_q, pri_d;
  logic [CntW-1:0] wait_cnt_q, wait_cnt_d;

  logic a_sel, b_sel;
  logic a_oor, b_oor;

  assign a_oor = addr_oor(a_addr, DEPTH_WORDS);
  assign b_oor = addr_oor(b_addr, DEPTH_WORDS);

  // Grants are gated by rst_n so nothing reaches memory while reset is held.
  always_comb begin
    a_sel = 1'b0;
    b_sel = 1'b0;
    if (rst_n) begin
      if (pri_q == PriA) begin
        if (a_req) begin
          a_sel = 1'b1;
        end else if (b_req) begin
          b_sel = 1'b1;
        end
      end else begin
        if (b_req) begin
          b_sel = 1'b1;
        end else if (a_req) begin
          a_sel = 1'b1;
        end
      end
    end
  end

  assign a_gnt = a_sel;
  assign b_gnt = b_sel;

  always_comb begin
    mem_add = 32'h0;
    mem_wd  = 32'h0;
    mem_mw  = 1'b0;
    mem_mre = 1'b0;
    if (a_sel) begin
      mem_add = a_addr;
      mem_wd  = a_wdata;
      mem_mre = ~a_we;
      mem_mw  = a_we & ~a_oor;
    end else if (b_sel) begin
      mem_add = b_addr;
      mem_wd  = b_wdata;
      mem_mre = ~b_we;
      mem_mw  = b_we & ~b_oor;
    end
  end

  always_comb begin
    wait_cnt_d = wait_cnt_q;
    if (b_sel) begin
      wait_cnt_d = '0;
    end else if (b_req && (wait_cnt_q != CntMax)) begin
      wait_cnt_d = wait_cnt_q + CntW'(1);
    end
  end

  // B keeps priority until it is actually served, so PriB is left only on a B grant.
  always_comb begin
    pri_d = pri_q;
    unique case (pri_q)
      PriA: begin
        if (b_req && !b_sel && (wait_cnt_d == CntMax)) begin
          pri_d = PriB;
        end
      end
      PriB: begin
        if (b_sel) begin
          pri_d = PriA;
        end
      end
      default: pri_d = PriA;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pri_q      <= PriA;
      wait_cnt_q <= '0;
    end else begin
      pri_q      <= pri_d;
      wait_cnt_q <= wait_cnt_d;
    end
  end

  dmem_port_resp u_resp_a (
    .clk_i    (clk),
    .rst_ni   (rst_n),
    .gnt_i    (a_sel),
    .we_i     (a_we),
    .oor_i    (a_oor),
    .mem_rd_i (mem_rd),
    .rdata_o  (a_rdata),
    .rvalid_o (a_rvalid),
    .err_o    (a_err)
  );

  dmem_port_resp u_resp_b (
    .clk_i    (clk),
    .rst_ni   (rst_n),
    .gnt_i    (b_sel),
    .we_i     (b_we),
    .oor_i    (b_oor),
    .mem_rd_i (mem_rd),
    .rdata_o  (b_rdata),
    .rvalid_o (b_rvalid),
    .err_o    (b_err)
  );

endmodule

// File: tb/tb_dmem_arbiter.sv
// Self-checking bench for dmem_arbiter: directed scenarios followed by random traffic,
// all compared against a behavioural model of arbitration, memory and responses.
module tb_dmem_arbiter;
  import dmem_arbiter_pkg::*;

  localparam int unsigned MaxWait = 3;
  localparam int unsigned Depth   = 128;
  localparam int unsigned Aw      = $clog2(Depth);

  logic        clk = 1'b0;
  logic        rst_n;
  logic        a_req, a_we, b_req, b_we;
  logic [31:0] a_addr, a_wdata, b_addr, b_wdata;
  logic        a_gnt, a_rvalid, a_err, b_gnt, b_rvalid, b_err;
  logic [31:0] a_rdata, b_rdata;
  logic [31:0] mem_add, mem_wd, mem_rd;
  logic        mem_mw, mem_mre;

  always #5 clk = ~clk;

  dmem_arbiter #(
    .MAX_WAIT    (MaxWait),
    .DEPTH_WORDS (Depth)
  ) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .a_req    (a_req),
    .a_we     (a_we),
    .a_addr   (a_addr),
    .a_wdata  (a_wdata),
    .a_gnt    (a_gnt),
    .a_rvalid (a_rvalid),
    .a_err    (a_err),
    .a_rdata  (a_rdata),
    .b_req    (b_req),
    .b_we     (b_we),
    .b_addr   (b_addr),
    .b_wdata  (b_wdata),
    .b_gnt    (b_gnt),
    .b_rvalid (b_rvalid),
    .b_err    (b_err),
    .b_rdata  (b_rdata),
    .mem_add  (mem_add),
    .mem_wd   (mem_wd),
    .mem_mw   (mem_mw),
    .mem_mre  (mem_mre),
    .mem_rd   (mem_rd)
  );

  // Physical memory attached to the arbiter; writes commit at the negedge.
  logic [31:0] mem [Depth];
  logic        mem_clr;
  logic        stray_write = 1'b0;
  logic [29:0] mem_idx;
  assign mem_idx = mem_add[31:2];
  assign mem_rd  = (mem_mre && ({2'b00, mem_idx} < Depth)) ? mem[mem_idx[Aw-1:0]] : 32'hBAD0_BAD0;

  always @(negedge clk) begin
    if (mem_clr) begin
      for (int i = 0; i < Depth; i++) mem[i] <= 32'h0;
    end else if (mem_mw) begin
      if ({2'b00, mem_idx} < Depth) mem[mem_idx[Aw-1:0]] <= mem_wd;
      else stray_write <= 1'b1;
    end
  end

  // Reference model state
  logic [31:0] ref_mem [Depth];
  int          losses;
  logic        exp_a_rv, exp_a_err, exp_b_rv, exp_b_err;
  logic [31:0] exp_a_rdata, exp_b_rdata;
  logic        mgnt_a, mgnt_b;
  logic        obs_a_gnt, obs_b_gnt, obs_mw;

  int n_checks = 0;
  int n_errors = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  function automatic logic is_oor(input logic [31:0] addr);
    return {2'b00, addr[31:2]} >= Depth;
  endfunction

  task automatic model_reset();
    losses      = 0;
    exp_a_rv    = 1'b0;
    exp_a_err   = 1'b0;
    exp_a_rdata = 32'h0;
    exp_b_rv    = 1'b0;
    exp_b_err   = 1'b0;
    exp_b_rdata = 32'h0;
    mgnt_a      = 1'b0;
    mgnt_b      = 1'b0;
  endtask

  // Called at posedge+1 with this cycle's inputs applied; returns at the next posedge+1.
  task automatic cycle();
    logic        ga, gb, we;
    logic [31:0] addr, wd;
    logic [31:0] e_add, e_wd;
    logic        e_mw, e_mre;
    #2;
    gb = b_req && (!a_req || (losses >= MaxWait));
    ga = a_req && !gb;
    e_add = 32'h0; e_wd = 32'h0; e_mw = 1'b0; e_mre = 1'b0;
    we = 1'b0; addr = 32'h0; wd = 32'h0;
    if (ga || gb) begin
      we    = ga ? a_we : b_we;
      addr  = ga ? a_addr : b_addr;
      wd    = ga ? a_wdata : b_wdata;
      e_add = addr;
      e_wd  = wd;
      e_mre = !we;
      e_mw  = we && !is_oor(addr);
    end
    obs_a_gnt = a_gnt;
    obs_b_gnt = b_gnt;
    obs_mw    = mem_mw;
    chk("a_gnt", 32'(a_gnt), 32'(ga));
    chk("b_gnt", 32'(b_gnt), 32'(gb));
    chk("mem_add", mem_add, e_add);
    chk("mem_wd", mem_wd, e_wd);
    chk("mem_mw", 32'(mem_mw), 32'(e_mw));
    chk("mem_mre", 32'(mem_mre), 32'(e_mre));

    exp_a_rv  = ga && !we;
    exp_a_err = ga && is_oor(addr);
    exp_b_rv  = gb && !we;
    exp_b_err = gb && is_oor(addr);
    if ((ga || gb) && !we) begin
      if (ga) exp_a_rdata = is_oor(addr) ? 32'h0 : ref_mem[addr[Aw+1:2]];
      else    exp_b_rdata = is_oor(addr) ? 32'h0 : ref_mem[addr[Aw+1:2]];
    end
    if (e_mw) ref_mem[addr[Aw+1:2]] = wd;
    if (gb) losses = 0;
    else if (b_req && losses < MaxWait) losses++;
    mgnt_a = ga;
    mgnt_b = gb;

    @(posedge clk);
    #1;
    chk("a_rvalid", 32'(a_rvalid), 32'(exp_a_rv));
    chk("a_err", 32'(a_err), 32'(exp_a_err));
    chk("a_rdata", a_rdata, exp_a_rdata);
    chk("b_rvalid", 32'(b_rvalid), 32'(exp_b_rv));
    chk("b_err", 32'(b_err), 32'(exp_b_err));
    chk("b_rdata", b_rdata, exp_b_rdata);
  endtask

  function automatic logic [31:0] rand_addr();
    logic [31:0] w;
    if ($urandom_range(0, 9) == 0) w = $urandom_range(Depth, Depth + 500);
    else w = $urandom_range(0, 15);
    return {w[29:0], 2'($urandom_range(0, 3))};
  endfunction

  task automatic new_req(output logic req, output logic we, output logic [31:0] addr,
                         output logic [31:0] wdata);
    req   = ($urandom_range(0, 99) < 70);
    we    = 1'($urandom_range(0, 1));
    addr  = rand_addr();
    wdata = $urandom;
  endtask

  function automatic int mem_diffs();
    int d = 0;
    for (int i = 0; i < Depth; i++) if (mem[i] !== ref_mem[i]) d++;
    return d;
  endfunction

  initial begin
    logic [7:0] seq;
    rst_n = 1'b0; mem_clr = 1'b1;
    a_req = 1'b1; a_we = 1'b0; a_addr = 32'h10; a_wdata = 32'h0;
    b_req = 1'b0; b_we = 1'b0; b_addr = 32'h0;  b_wdata = 32'h0;
    for (int i = 0; i < Depth; i++) ref_mem[i] = 32'h0;
    model_reset();

    // Reset state, with a request pending
    #2;
    chk("rst_a_gnt", 32'(a_gnt), 32'h0);
    chk("rst_mem_mre", 32'(mem_mre), 32'h0);
    chk("rst_a_rvalid", 32'(a_rvalid), 32'h0);
    chk("rst_a_err", 32'(a_err), 32'h0);
    chk("rst_a_rdata", a_rdata, 32'h0);
    chk("rst_b_rdata", b_rdata, 32'h0);
    @(posedge clk); @(posedge clk); #1;
    mem_clr = 1'b0; rst_n = 1'b1; a_req = 1'b0;

    // Contested arbitration: expect A,A,A,B,A,A,A,B
    a_req = 1'b1; a_we = 1'b0; a_addr = 32'h0;
    b_req = 1'b1; b_we = 1'b0; b_addr = 32'h4;
    seq = 8'h0;
    repeat (8) begin
      cycle();
      seq = {seq[6:0], obs_b_gnt};
    end
    chk("grant_order", 32'(seq), 32'h11);
    a_req = 1'b0; b_req = 1'b0;
    cycle();

    // A write then read back
    a_req = 1'b1; a_we = 1'b1; a_addr = 32'h10; a_wdata = 32'hDEAD_BEEF;
    cycle();
    chk("wr_mem_mw", 32'(obs_mw), 32'h1);
    a_we = 1'b0;
    cycle();
    a_req = 1'b0;
    chk("rd_a_rvalid", 32'(a_rvalid), 32'h1);
    chk("rd_a_rdata", a_rdata, 32'hDEAD_BEEF);
    cycle();

    // B write out of range
    b_req = 1'b1; b_we = 1'b1; b_addr = 32'h200; b_wdata = 32'h1234_5678;
    cycle();
    b_req = 1'b0;
    chk("oorw_b_gnt", 32'(obs_b_gnt), 32'h1);
    chk("oorw_mem_mw", 32'(obs_mw), 32'h0);
    chk("oorw_b_err", 32'(b_err), 32'h1);
    cycle();
    chk("oorw_mem_unchanged", 32'(mem_diffs()), 32'h0);
    chk("oorw_no_stray", 32'(stray_write), 32'h0);

    // B back-to-back reads
    b_req = 1'b1; b_we = 1'b0;
    for (int i = 0; i < 4; i++) begin
      b_addr = 32'(i * 4);
      cycle();
      chk("burst_b_gnt", 32'(obs_b_gnt), 32'h1);
      chk("burst_b_rvalid", 32'(b_rvalid), 32'h1);
    end
    b_req = 1'b0;
    chk("burst_wait_cnt", 32'(dut.wait_cnt_q), 32'h0);
    cycle();

    // A read out of range
    a_req = 1'b1; a_we = 1'b0; a_addr = 32'h400;
    cycle();
    a_req = 1'b0;
    chk("oorr_a_rvalid", 32'(a_rvalid), 32'h1);
    chk("oorr_a_err", 32'(a_err), 32'h1);
    chk("oorr_a_rdata", a_rdata, 32'h0);
    cycle();

    // Reset asserted in the middle of an A read grant
    a_req = 1'b1; a_we = 1'b0; a_addr = 32'h10;
    #2;
    chk("midrst_pre_gnt", 32'(a_gnt), 32'h1);
    rst_n = 1'b0;
    #1;
    chk("midrst_a_gnt", 32'(a_gnt), 32'h0);
    chk("midrst_mem_mre", 32'(mem_mre), 32'h0);
    @(posedge clk); #1;
    chk("midrst_a_rvalid", 32'(a_rvalid), 32'h0);
    a_req = 1'b0; rst_n = 1'b1;
    model_reset();
    chk("midrst_a_rdata", a_rdata, 32'h0);
    chk("midrst_pri", 32'(dut.pri_q), 32'(PriA));
    cycle();

    // Random traffic; requests are held until granted
    for (int i = 0; i < 400; i++) begin
      if (!a_req || mgnt_a) new_req(a_req, a_we, a_addr, a_wdata);
      if (!b_req || mgnt_b) new_req(b_req, b_we, b_addr, b_wdata);
      cycle();
    end
    a_req = 1'b0; b_req = 1'b0;
    cycle();
    chk("final_mem", 32'(mem_diffs()), 32'h0);
    chk("final_no_stray", 32'(stray_write), 32'h0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/dmem_arbiter.md
DMEM_ARBITER -- requirements
Module: dmem_arbiter

Interface
REQ-001: Parameter MAX_WAIT, default 3: contested cycles port B may lose before it gets priority.
REQ-002: Parameter DEPTH_WORDS, default 128: number of data-memory words, valid word addresses 0..DEPTH_WORDS-1.
REQ-003: clk  in  1  single clock; all state updates on posedge.
REQ-004: rst_n  in  1  reset, asynchronous and active-low.
REQ-005: a_req, a_we  in  1 each  pipeline MEM-stage request and write-enable (port A).
REQ-006: a_addr, a_wdata  in  32 each  port A byte address and write data.
REQ-007: a_gnt  out  1  port A accepted this cycle (combinational).
REQ-008: a_rvalid, a_err  out  1 each  registered one-cycle pulses: read data ready, or out-of-range access.
REQ-009: a_rdata  out  32  registered read data.
REQ-010: b_req, b_we, b_addr, b_wdata, b_gnt, b_rvalid, b_err, b_rdata: the same set for the debug/DMA port (port B).
REQ-011: mem_add, mem_wd  out  32 each  to the memory address and write-data inputs.
REQ-012: mem_mw, mem_mre  out  1 each  to the memory write and read enables.
REQ-013: mem_rd  in  32  memory read data, combinational from mem_add when mem_mre=1.

Function
REQ-014: At most one port is granted per cycle; a_gnt and b_gnt are never 1 together.
REQ-015: Priority FSM has two states, PRI_A and PRI_B; reset state is PRI_A.
REQ-016: In PRI_A: grant A if a_req=1, else grant B if b_req=1.
REQ-017: In PRI_B: grant B if b_req=1, else grant A if a_req=1.
REQ-018: Starvation counter wait_cnt (2 bits min, saturating at MAX_WAIT) increments on each cycle with b_req=1 and b_gnt=0, and clears on b_gnt=1.
REQ-019: PRI_A goes to PRI_B on the posedge where wait_cnt would reach MAX_WAIT; PRI_B goes to PRI_A on the posedge after any b_gnt=1.
REQ-020: Requester holds req, we, addr and wdata stable until it sees gnt=1; the access completes in the grant cycle.
REQ-021: In a granted cycle, mem_add, mem_wd and mem_mre=~we come from the granted port; mem_mw=we only if the address is in range.
REQ-022: In a cycle with no grant, mem_mw=0, mem_mre=0, mem_add=0 and mem_wd=0.
REQ-023: A write is committed by the memory at the negedge inside the grant cycle; the port gets no response pulse for it.
REQ-024: A read is captured from mem_rd at the posedge ending the grant cycle; at that posedge rdata is loaded and rvalid=1 for exactly one cycle (latency 1).
REQ-025: An access is out of range when addr[31:2] >= DEPTH_WORDS; it is granted but the write is suppressed.
REQ-026: For an out-of-range access, err pulses 1 cycle after the grant; for a read, rvalid also pulses and rdata=0.
REQ-027: rdata holds its value between reads; rvalid and err are 0 in every cycle without a qualifying event.
REQ-028: Byte address bits [1:0] are ignored (word access only).
REQ-029: Back-to-back grants to the same port, one per cycle, are supported without bubbles.

Reset
REQ-030: While rst_n=0, asynchronously: FSM=PRI_A, wait_cnt=0, all rvalid/err=0, all rdata=0.
REQ-031: While rst_n=0, a_gnt, b_gnt, mem_mw and mem_mre are forced 0, including reset asserted mid-access.
REQ-032: A read granted in the cycle where reset asserts produces no rvalid after reset releases.

Structure
REQ-033: A shared package holds the FSM state encoding (PRI_A=0, PRI_B=1) and the default MAX_WAIT and DEPTH_WORDS constants.
REQ-034: One sub-module, dmem_port_resp, holds the per-port response registers (rdata, rvalid, err) and is instantiated twice.

Verification
REQ-035: Bench covers: A writes 0xDEADBEEF at addr 0x10, then reads 0x10 -> a_rvalid=1 one cycle after the read grant, a_rdata=0xDEADBEEF.
REQ-036: Bench covers: a_req and b_req held high for 8 cycles, MAX_WAIT=3 -> grant order A,A,A,B,A,A,A,B.
REQ-037: Bench covers: B write at addr 0x200 (word 128) -> b_gnt=1, mem_mw=0, b_err pulses next cycle, memory contents unchanged.
REQ-038: Bench covers: rst_n low mid-way through an A read grant -> a_gnt=0 and mem_mre=0 at once; no a_rvalid after release; FSM=PRI_A.
REQ-039: Bench covers: only b_req high for 4 cycles with reads 0x0, 0x4, 0x8, 0xC -> 4 consecutive b_gnt, 4 b_rvalid pulses each 1 cycle later, wait_cnt=0.
REQ-040: Bench covers: out-of-range A read -> a_rvalid=1, a_err=1, a_rdata=0.
